// File: rtl/gf_mul_arbiter.sv
// gf_mul_arbiter
//   Round-robin arbiter that shares one GF(2^WIDTH) field multiplier among
//   N_REQ requesters using a level-start / pulse-done handshake. The granted
//   requester's operands are registered toward the multiplier, the product is
//   registered back together with a one-cycle done pulse to the owner, and
//   protocol errors (spurious m_done, watchdog timeout) are flagged stickily.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   req      [N]      per-requester start level, held until its done is seen
//   req_a/req_b       packed operands, requester i at [i*WIDTH +: WIDTH]
//   grant    [N]      one-hot multiplier owner, zero when idle
//   done     [N]      one-cycle pulse to the owner when result is valid
//   result   [W]      registered product, held until the next completion
//   m_start           level start to the multiplier
//   m_a/m_b  [W]      registered operands to the multiplier
//   m_done, m_result  completion pulse and product from the multiplier
//   err, err_code[2]  sticky error flag; first error (01 spurious, 10 timeout)

module gf_mul_arbiter #(
    parameter int N_REQ   = 2,
    parameter int WIDTH   = 163,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       result,
    output logic                   m_start,
    output logic [WIDTH-1:0]       m_a,
    output logic [WIDTH-1:0]       m_b,
    input  logic                   m_done,
    input  logic [WIDTH-1:0]       m_result,
    output logic                   err,
    output logic [1:0]             err_code
);

    localparam int         PTR_W    = $clog2(N_REQ);
    localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, DONE, GAP} state_t;
    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_SPURIOUS = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               m_start_q, m_start_d;
    logic [WIDTH-1:0]   m_a_q, m_a_d;
    logic [WIDTH-1:0]   m_b_q, m_b_d;
    logic               err_q, err_d;
    err_t               err_code_q, err_code_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   mask_q, mask_d;
    logic [9:0]         wd_q, wd_d;

    logic [N_REQ-1:0]   eligible;
    logic [PTR_W-1:0]   sel;

    // Requester index reached by stepping k places upward from p, wrapping.
    function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return PTR_W'(s);
    endfunction

    // Round-robin pick: first eligible requester at or above ptr, wrapping.
    always_comb begin
        eligible = req & ~mask_q;
        sel      = ptr_q;
        // Scan from the far end so the smallest offset from ptr wins last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (eligible[rot_idx(ptr_q, k)]) sel = rot_idx(ptr_q, k);
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = '0;
        result_d   = result_q;
        m_start_d  = m_start_q;
        m_a_d      = m_a_q;
        m_b_d      = m_b_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        mask_d     = mask_q;
        wd_d       = wd_q;

        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    owner_d      = sel;
                    m_a_d        = req_a[sel*WIDTH +: WIDTH];
                    m_b_d        = req_b[sel*WIDTH +: WIDTH];
                    m_start_d    = 1'b1;
                    wd_d         = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (m_done) begin
                    result_d  = m_result;
                    done_d    = grant_q;
                    m_start_d = 1'b0;
                    state_d   = DONE;
                end else if (wd_q + 10'd1 == WD_LIMIT) begin
                    // Multiplier never answered: release it without a done
                    // pulse; the owner stays stalled until reset.
                    m_start_d = 1'b0;
                    grant_d   = '0;
                    err_d     = 1'b1;
                    if (err_code_q == ERR_NONE) err_code_d = ERR_TIMEOUT;
                    state_d   = GAP;
                end else begin
                    wd_d = wd_q + 10'd1;
                end
            end
            DONE: begin
                ptr_d   = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                // Hide the owner's request while it is still deasserting.
                mask_d  = grant_q;
                grant_d = '0;
                state_d = GAP;
            end
            GAP: begin
                mask_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A completion outside RUN has no owner to deliver to.
        if (m_done && state_q != RUN) begin
            err_d = 1'b1;
            if (err_code_q == ERR_NONE) err_code_d = ERR_SPURIOUS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            // NOTE: the wide operand/result registers are reset too, because
            // they are outputs whose idle value must be defined after reset.
            result_q   <= '0;
            m_start_q  <= 1'b0;
            m_a_q      <= '0;
            m_b_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            ptr_q      <= '0;
            owner_q    <= '0;
            mask_q     <= '0;
            wd_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            result_q   <= result_d;
            m_start_q  <= m_start_d;
            m_a_q      <= m_a_d;
            m_b_q      <= m_b_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            mask_q     <= mask_d;
            wd_q       <= wd_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign result   = result_q;
    assign m_start  = m_start_q;
    assign m_a      = m_a_q;
    assign m_b      = m_b_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_gf_mul_arbiter.sv
// Self-checking bench for gf_mul_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// transaction-level model of the arbiter and a GF(2^163) multiplier model.

module tb_gf_mul_arbiter;

    localparam int N_REQ   = 2;
    localparam int WIDTH   = 163;
    localparam int TIMEOUT = 20;
    localparam logic [WIDTH-1:0] RED = 'hC9;  // x^163 = x^7+x^6+x^3+1

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_a, req_b;
    logic [N_REQ-1:0]       grant, done;
    logic [WIDTH-1:0]       result;
    logic                   m_start;
    logic [WIDTH-1:0]       m_a, m_b;
    logic                   m_done;
    logic [WIDTH-1:0]       m_result;
    logic                   err;
    logic [1:0]             err_code;

    gf_mul_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .grant(grant), .done(done), .result(result), .m_start(m_start),
        .m_a(m_a), .m_b(m_b), .m_done(m_done), .m_result(m_result),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference functions ----------------
    function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] acc, x;
        acc = '0;
        x   = a;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) acc ^= x;
            x = x[WIDTH-1] ? ((x << 1) ^ RED) : (x << 1);
        end
        return acc;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_elem();
        logic [191:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[WIDTH-1:0];
    endfunction

    // ---------------- arbiter model (transaction timeline) ----------------
    logic [N_REQ-1:0] exp_grant, exp_done;
    logic [WIDTH-1:0] exp_result, exp_ma, exp_mb;
    logic             exp_mstart, exp_err;
    logic [1:0]       exp_code;
    bit               mo_run;    // a multiply is outstanding
    int               mo_owner;
    int               mo_cnt;    // RUN cycles without completion
    int               mo_cool;   // non-idle cycles left before the next pick
    int               rr_ptr;

    task automatic model_reset();
        exp_grant = '0; exp_done = '0; exp_result = '0; exp_ma = '0; exp_mb = '0;
        exp_mstart = 1'b0; exp_err = 1'b0; exp_code = 2'b00;
        mo_run = 1'b0; mo_owner = 0; mo_cnt = 0; mo_cool = 0; rr_ptr = 0;
    endtask

    // Advance the model across one rising edge, using the inputs present at it.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        exp_done = '0;
        if (mo_run) begin
            if (m_done) begin
                exp_result         = m_result;
                exp_done[mo_owner] = 1'b1;
                exp_mstart         = 1'b0;
                mo_run             = 1'b0;
                mo_cool            = 2;
                rr_ptr             = (mo_owner + 1) % N_REQ;
            end else begin
                mo_cnt++;
                if (mo_cnt == TIMEOUT) begin
                    exp_mstart = 1'b0;
                    exp_grant  = '0;
                    exp_err    = 1'b1;
                    if (exp_code == 2'b00) exp_code = 2'b10;
                    mo_run  = 1'b0;
                    mo_cool = 1;
                end
            end
        end else begin
            if (m_done) begin
                exp_err = 1'b1;
                if (exp_code == 2'b00) exp_code = 2'b01;
            end
            if (mo_cool > 0) begin
                exp_grant = '0;
                mo_cool--;
            end else begin
                for (int k = 0; k < N_REQ; k++) begin
                    int idx = (rr_ptr + k) % N_REQ;
                    if (req[idx]) begin
                        exp_grant      = '0;
                        exp_grant[idx] = 1'b1;
                        exp_ma         = req_a[idx*WIDTH +: WIDTH];
                        exp_mb         = req_b[idx*WIDTH +: WIDTH];
                        exp_mstart     = 1'b1;
                        mo_run         = 1'b1;
                        mo_owner       = idx;
                        mo_cnt         = 0;
                        break;
                    end
                end
            end
        end
    endtask

    // ---------------- compare process ----------------
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_grant",    grant,    exp_grant);
            check("cyc_done",     done,     exp_done);
            check("cyc_result",   result,   exp_result);
            check("cyc_m_start",  m_start,  exp_mstart);
            check("cyc_m_a",      m_a,      exp_ma);
            check("cyc_m_b",      m_b,      exp_mb);
            check("cyc_err",      err,      exp_err);
            check("cyc_err_code", err_code, exp_code);
        end
    end

    // ---------------- stimulus: requesters and multiplier ----------------
    bit auto_mode = 1'b0;
    bit reissue   = 1'b0;
    bit spur_req  = 1'b0;
    bit mul_hang  = 1'b0;
    int mul_lat   = 0;     // 0 selects a random latency
    bit mul_busy  = 1'b0;
    int mul_cnt   = 0;

    task automatic drive_next();
        bit fire;
        if (auto_mode) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i]) begin
                    if (done[i]) req[i] = reissue && ($urandom_range(0, 1) == 1);
                    else if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                end
                req_a[i*WIDTH +: WIDTH] = rnd_elem();
                req_b[i*WIDTH +: WIDTH] = rnd_elem();
            end
            if ($urandom_range(0, 79) == 0) spur_req = 1'b1;
        end
        fire = 1'b0;
        if (!rst_n || !m_start) begin
            mul_busy = 1'b0;
        end else begin
            if (!mul_busy) begin
                mul_busy = 1'b1;
                mul_cnt  = (mul_lat != 0) ? mul_lat : $urandom_range(1, 15);
            end
            fire = !mul_hang && (mul_cnt == 1);
            mul_cnt--;
        end
        m_done   = fire;
        m_result = fire ? gf_mul(m_a, m_b) : rnd_elem();
        if (spur_req) begin
            m_done   = 1'b1;
            m_result = rnd_elem();
            spur_req = 1'b0;
        end
    endtask

    int cyc = 0;
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        drive_next();
    endtask

    task automatic do_reset();
        req    = '0;
        rst_n  = 1'b0;
        model_reset();
        step();
        rst_n  = 1'b1;
    endtask

    task automatic wait_done(input int idx, input int budget, output int waited);
        waited = 0;
        while (!done[idx] && waited < budget) begin
            step();
            waited++;
        end
        check($sformatf("done%0d_within_%0d", idx, budget), done[idx], 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w, cnt_g, cnt_d;
        int glog[$];
        logic [N_REQ-1:0] prev_g;
        logic [WIDTH-1:0] t;

        rst_n = 1'b0; req = '0; req_a = '0; req_b = '0;
        m_done = 1'b0; m_result = '0;
        model_reset();
        chk_en = 1'b1;

        // Model pins.
        check("pin_gf_3x5", gf_mul('h3, 'h5), 'hF);
        t = '0; t[WIDTH-1] = 1'b1;
        check("pin_gf_reduce", gf_mul(t, 'h2), RED);

        do_reset();
        check("rst_grant", grant, '0);
        check("rst_m_start", m_start, 1'b0);
        check("rst_err_code", err_code, 2'b00);

        // Single requester, 10-cycle multiplier.
        mul_lat = 10;
        req_a[0 +: WIDTH] = 'h3; req_b[0 +: WIDTH] = 'h5; req[0] = 1'b1;
        step();
        check("t1_m_start", m_start, 1'b1);
        check("t1_grant", grant, 2'b01);
        wait_done(0, 40, w);
        check("t1_latency", w, 10);
        check("t1_result", result, 'hF);
        check("t1_done", done, 2'b01);
        req[0] = 1'b0;
        step();
        check("t1_pulse_len", done, 2'b00);
        step();                                    // IDLE, 3 cycles after m_done
        req_a[0 +: WIDTH] = 'h7; req_b[0 +: WIDTH] = 'h3; req[0] = 1'b1;
        mul_lat = 4;
        step();
        check("t1_regrant_at_idle", grant, 2'b01);

        // Mask: stale request held through the done and GAP cycles.
        wait_done(0, 40, w);
        check("mask_result", result, 'h9);
        step();
        check("mask_gap_grant", grant, 2'b00);
        check("mask_gap_done", done, 2'b00);
        step();
        req[0] = 1'b0;
        cnt_g = 0; cnt_d = 0;
        repeat (5) begin
            step();
            if (grant != 0) cnt_g++;
            if (done != 0) cnt_d++;
        end
        check("mask_no_stale_grant", cnt_g, 0);
        check("mask_no_second_done", cnt_d, 0);
        req[0] = 1'b1;
        step();
        check("mask_regrant", grant, 2'b01);
        wait_done(0, 40, w);
        req[0] = 1'b0;
        repeat (3) step();

        // Spurious done while idle.
        spur_req = 1'b1;
        step();
        step();
        check("spur_err", err, 1'b1);
        check("spur_code", err_code, 2'b01);
        check("spur_result_kept", result, 'h9);
        check("spur_no_done", done, 2'b00);
        req_a[WIDTH +: WIDTH] = 'h6; req_b[WIDTH +: WIDTH] = 'h6; req[1] = 1'b1;
        wait_done(1, 40, w);
        check("spur_next_result", result, 'h14);
        check("spur_next_done", done, 2'b10);
        check("spur_err_sticky", err, 1'b1);
        req[1] = 1'b0;
        repeat (3) step();

        // Contention: both held, each re-requests right after its done.
        do_reset();
        mul_lat = 0;
        req = 2'b11;
        glog.delete();
        prev_g = '0;
        for (int n = 0; n < 300 && glog.size() < 4; n++) begin
            step();
            if (grant != 0 && prev_g == 0) glog.push_back(grant[1] ? 1 : 0);
            prev_g = grant;
        end
        check("cont_grants", glog.size(), 4);
        for (int k = 0; k < glog.size(); k++) check($sformatf("cont_order%0d", k), glog[k], k % 2);
        req = '0;
        repeat (25) step();

        // Watchdog timeout.
        do_reset();
        mul_hang = 1'b1;
        req_a[0 +: WIDTH] = rnd_elem(); req_b[0 +: WIDTH] = rnd_elem(); req[0] = 1'b1;
        step();
        repeat (TIMEOUT - 1) step();
        check("to_m_start_last_run", m_start, 1'b1);
        step();
        check("to_m_start_drop", m_start, 1'b0);
        check("to_grant", grant, 2'b00);
        check("to_code", err_code, 2'b10);
        check("to_err", err, 1'b1);
        check("to_no_done", done, 2'b00);
        req[0] = 1'b0;
        mul_hang = 1'b0;
        repeat (4) step();

        // Reset at RUN cycle 5, then a late m_done.
        do_reset();
        mul_lat = 15;
        req_a[0 +: WIDTH] = rnd_elem(); req_b[0 +: WIDTH] = rnd_elem(); req[0] = 1'b1;
        step();
        repeat (4) step();
        rst_n = 1'b0;
        req = '0;
        model_reset();
        #1;
        check("rr_grant", grant, '0);
        check("rr_m_start", m_start, 1'b0);
        check("rr_m_a", m_a, '0);
        check("rr_result", result, '0);
        check("rr_err", err, 1'b0);
        step();
        rst_n = 1'b1;
        spur_req = 1'b1;
        step();
        step();
        check("rr_late_done_code", err_code, 2'b01);

        // Randomized traffic.
        do_reset();
        mul_lat = 0;
        auto_mode = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) reissue = ($urandom_range(0, 1) == 1);
            step();
        end
        auto_mode = 1'b0;
        req = '0;
        repeat (40) step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
